// File: rtl/edic_step_pkg.sv
// Shared types and constants for the EDiC step controller.
//   step_state_t            : controller FSM state encoding (visible on o_state)
//   DEFAULT_DEBOUNCE_CYCLES : 5 ms at 100 MHz
package edic_step_pkg;

  typedef enum logic [1:0] {
    S_HALT       = 2'd0,
    S_RUN        = 2'd1,
    S_STEP_CYCLE = 2'd2,
    S_STEP_INSTR = 2'd3
  } step_state_t;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/step_debounce.sv
// Button conditioner: 2-FF synchronizer, debounce counter, rising-edge pulse.
//   clk      : system clock
//   reset    : synchronous, active-high
//   btn      : raw asynchronous button level (1 = pressed)
//   step_req : one-cycle pulse, 2 + DEBOUNCE_CYCLES + 1 cycles after a press
module step_debounce
  import edic_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic step_req
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      level    <= 1'b0;
      level_d  <= 1'b0;
      cnt      <= '0;
      step_req <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing
      // cycle; any agreeing cycle restarts the count.
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      step_req <= level & ~level_d;
    end
  end

endmodule

// File: rtl/step_controller.sv
// EDiC emulation step controller: turns oscillator ticks into CPU clock-enable
// pulses in run, cycle-step, instruction-step and breakpoint-halt modes.
//   i_clk100 / i_reset       : clock, synchronous active-high reset
//   i_oszTick                : one-cycle CPU oscillator tick
//   i_btnStep                : raw step button
//   i_swStepNRun             : 1 = step mode, 0 = run mode
//   i_swInstrNCycle          : step granularity (1 = instruction, 0 = cycle)
//   i_swEnableBreakpoint     : enable PC breakpoint in run mode
//   i_breakpointAddress/i_pc : breakpoint PC and current CPU PC
//   i_instrStart             : next enabled cycle fetches i_pc
//   o_cpuClkEn               : registered one-cycle advance pulse
//   o_halted / o_bpHit       : in S_HALT / halted by breakpoint (sticky)
//   o_state                  : current FSM state
module step_controller
  import edic_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned ADDR_WIDTH      = 16
) (
  input  logic                  i_clk100,
  input  logic                  i_reset,
  input  logic                  i_oszTick,
  input  logic                  i_btnStep,
  input  logic                  i_swStepNRun,
  input  logic                  i_swInstrNCycle,
  input  logic                  i_swEnableBreakpoint,
  input  logic [ADDR_WIDTH-1:0] i_breakpointAddress,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_instrStart,
  output logic                  o_cpuClkEn,
  output logic                  o_halted,
  output logic                  o_bpHit,
  output logic [1:0]            o_state
);

  step_state_t state, state_n;
  logic        bp_hit, bp_hit_n;
  logic        bp_armed, bp_armed_n;
  logic        issued_once, issued_once_n;
  logic        issue;
  logic        clk_en;
  logic        step_req;
  logic        bp_match;

  step_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (i_clk100),
    .reset   (i_reset),
    .btn     (i_btnStep),
    .step_req(step_req)
  );

  assign bp_match = i_swEnableBreakpoint & bp_armed & i_instrStart &
                    (i_pc == i_breakpointAddress);

  always_comb begin
    state_n       = state;
    bp_hit_n      = bp_hit;
    bp_armed_n    = bp_armed;
    issued_once_n = issued_once;
    issue         = 1'b0;

    unique case (state)
      S_HALT: begin
        issued_once_n = 1'b0;
        if (step_req) begin
          // A step after a breakpoint disarms so the breakpoint instruction
          // itself can execute once before the compare is live again.
          if (bp_hit) begin
            bp_hit_n   = 1'b0;
            bp_armed_n = 1'b0;
          end
          if (i_swStepNRun) begin
            state_n = i_swInstrNCycle ? S_STEP_INSTR : S_STEP_CYCLE;
          end else begin
            state_n = S_RUN;
          end
        end else if (!i_swStepNRun && !bp_hit) begin
          state_n = S_RUN;
        end
      end

      S_RUN: begin
        if (i_oszTick && bp_match) begin
          bp_hit_n = 1'b1;
          state_n  = S_HALT;
        end else if (i_swStepNRun) begin
          state_n = S_HALT;
        end else if (i_oszTick) begin
          issue = 1'b1;
        end
      end

      S_STEP_CYCLE: begin
        if (i_oszTick) begin
          issue   = 1'b1;
          state_n = S_HALT;
        end
      end

      S_STEP_INSTR: begin
        if (i_oszTick) begin
          if (i_instrStart && issued_once) begin
            state_n = S_HALT;
          end else begin
            issue         = 1'b1;
            issued_once_n = 1'b1;
          end
        end
      end

      default: state_n = S_HALT;
    endcase

    if (issue && !i_instrStart) begin
      bp_armed_n = 1'b1;
    end
  end

  always_ff @(posedge i_clk100) begin
    if (i_reset) begin
      state       <= S_HALT;
      bp_hit      <= 1'b0;
      bp_armed    <= 1'b1;
      issued_once <= 1'b0;
      clk_en      <= 1'b0;
    end else begin
      state       <= state_n;
      bp_hit      <= bp_hit_n;
      bp_armed    <= bp_armed_n;
      issued_once <= issued_once_n;
      clk_en      <= issue;
    end
  end

  assign o_cpuClkEn = clk_en;
  assign o_halted   = (state == S_HALT);
  assign o_bpHit    = bp_hit;
  assign o_state    = state;

endmodule

// File: doc/step_controller.md
# step_controller

Sequences the EDiC CPU's advance in the FPGA emulation. It converts the slow oscillator tick into per-cycle CPU clock-enable pulses according to four modes: free run, single cycle step, single instruction step, and halt-on-breakpoint. It sits between the board controls (step button, mode switches, breakpoint address) and the generated CPU core. The CPU advances one microcycle per `o_cpuClkEn` pulse.

## Interface
- `DEBOUNCE_CYCLES`, 500000: stable `i_clk100` cycles required before a button level is accepted (5 ms).
- `ADDR_WIDTH`, 16: PC / breakpoint width.
- `i_clk100` in 1: system clock; sole clock of the block.
- `i_reset` in 1: synchronous, active-high reset.
- `i_oszTick` in 1: one-cycle pulse per CPU oscillator period (already in `i_clk100` domain).
- `i_btnStep` in 1: raw step button, 1 = pressed, asynchronous.
- `i_swStepNRun` in 1: 1 = step mode, 0 = run mode; quasi-static.
- `i_swInstrNCycle` in 1: in step mode, 1 = step instruction, 0 = step cycle.
- `i_swEnableBreakpoint` in 1: enables breakpoint compare.
- `i_breakpointAddress` in ADDR_WIDTH: breakpoint PC.
- `i_pc` in ADDR_WIDTH: current CPU PC.
- `i_instrStart` in 1: CPU microstep counter is 0, so the next enabled cycle fetches `i_pc`.
- `o_cpuClkEn` out 1: one-cycle advance pulse, registered; reset 0.
- `o_halted` out 1: state is S_HALT; reset 1.
- `o_bpHit` out 1: halted by breakpoint, sticky until resume; reset 0.
- `o_state` out 2: current state encoding; reset S_HALT.

## Operation
- **Button path**
  - 2-FF synchronizer, then a debounce counter.
  - The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - A 0→1 edge of the debounced level produces a one-cycle `stepReq`.
- **Tick qualification:** a tick is "issued" when `i_oszTick`=1 and the FSM allows it; issued ticks produce `o_cpuClkEn` one cycle later.
- **S_HALT**
  - No ticks are issued.
  - If `i_swStepNRun`=0 and `o_bpHit`=0: go to S_RUN next cycle.
  - On `stepReq`:
    - with `o_bpHit`=1 (any mode): clear `o_bpHit`, clear `bpArmed`, go to S_RUN if `i_swStepNRun`=0;
    - otherwise, if `i_swStepNRun`=1: go to S_STEP_CYCLE (`i_swInstrNCycle`=0) or S_STEP_INSTR (`i_swInstrNCycle`=1);
    - when `o_bpHit`=1 and `i_swStepNRun`=1, the step mode selected by `i_swInstrNCycle` is also entered, with `bpArmed` cleared.
- **S_RUN**
  - Every `i_oszTick` is issued, except a breakpoint tick.
  - Breakpoint tick: `i_swEnableBreakpoint`=1, `bpArmed`=1, `i_instrStart`=1 and `i_pc`==`i_breakpointAddress`.
  - On a breakpoint tick: tick suppressed, `o_bpHit`←1, go to S_HALT.
  - If `i_swStepNRun`=1 is sampled: go to S_HALT without issuing.
- **`bpArmed`:** set on any issued tick with `i_instrStart`=0. This guarantees the breakpoint instruction executes once after a resume. Reset value 1.
- **S_STEP_CYCLE:** issue exactly the next `i_oszTick`, then go to S_HALT in the same cycle.
- **S_STEP_INSTR**
  - Issue ticks until a tick arrives with `i_instrStart`=1 after at least one issued tick.
  - That tick is suppressed; go to S_HALT.
  - A step started mid-instruction therefore completes the current instruction only.
- Breakpoints are evaluated only in S_RUN.
- `stepReq` outside S_HALT is dropped.

## Timing
- `o_cpuClkEn` is asserted exactly in the cycle after the qualifying `i_oszTick`, and is always one cycle wide.
- Decisions use `i_pc` and `i_instrStart` sampled in the `i_oszTick` cycle.
- FSM transitions take effect on the clock edge ending the deciding cycle.
- Button press to `stepReq`: 2 + DEBOUNCE_CYCLES + 1 cycles.
- `stepReq` and `i_oszTick` in the same cycle: the tick is not issued. The first eligible tick is the next one.
- Mode switch changes are honoured only in S_HALT, or by S_RUN→S_HALT as described above. Step states always run to completion.
- `i_reset` mid-step: the pending `o_cpuClkEn` is cancelled (0 next cycle), the state returns to S_HALT, `o_bpHit`=0 and `bpArmed`=1. The debounced level and counter reset to 0.
- A breakpoint match and `i_swStepNRun`=1 in the same tick: go to S_HALT with `o_bpHit`=1.

## Structure
- Package `edic_step_pkg` contains:
  - `step_state_t` enum: S_HALT=0, S_RUN=1, S_STEP_CYCLE=2, S_STEP_INSTR=3;
  - default debounce constant.
- Sub-module `step_debounce`: synchronizer, counter and rising-edge pulse (params DEBOUNCE_CYCLES). It is reusable for other board buttons.
- The top level holds the FSM, `bpArmed`, `o_bpHit` and the output register.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and `i_oszTick` every 20 cycles.
- **Run mode:** `i_swStepNRun`=0 after reset → S_RUN after 1 cycle; each tick is followed by `o_cpuClkEn`=1 exactly 1 cycle later; 10 ticks give 10 pulses.
- **Breakpoint:** breakpoint 0x0028 enabled, CPU model reaches `i_pc`=0x0028 with `i_instrStart`=1.
  - The tick is suppressed; `o_halted`=1, `o_bpHit`=1.
  - A step press resumes; the first tick is issued although `i_pc` is still 0x0028.
  - A re-hit occurs only on the next arrival at 0x0028.
- **Cycle step:** `i_swStepNRun`=1, `i_swInstrNCycle`=0; a press held for 6 cycles gives exactly one `o_cpuClkEn`, then S_HALT.
- **Debounce:** a glitch of 3 cycles produces no step.
- **Instruction step:** CPU model with 3 microcycles per instruction, step starting at `i_instrStart`=1; a press gives 3 pulses, then S_HALT with `i_instrStart`=1. A press issued mid-instruction at microstep 1 gives 2 pulses.
- **Reset and simultaneity:** `i_reset` in the cycle after an issuing tick gives `o_cpuClkEn`=0, `o_state`=S_HALT, `o_bpHit`=0. A step press whose `stepReq` coincides with `i_oszTick` gives its pulse on the following tick (20 cycles later).
